// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared tap masks and tap lookup for the XNOR LFSR family
package lfsr_pkg;

  // Tap masks: a set bit marks a feedback tap position
  localparam logic [17:0] TAPS_18 = 18'h20400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // Tap mask for a supported width; an all-zero mask flags an unsupported width
  function automatic logic [31:0] taps_for(input int width);
    logic [31:0] mask;
    mask = '0;
    case (width)
      18:      mask = {14'd0, TAPS_18};
      32:      mask = TAPS_32;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_xnor.sv
// rtl/lfsr_xnor.sv - parameterised Fibonacci XNOR LFSR (18 or 32 bits)
module lfsr_xnor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0]      TAPS_FULL = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  // Only 18 and 32 have tap sets; anything else must stop elaboration
  generate
    if (TAPS_FULL == 32'd0) begin : g_bad_width
      $error("lfsr_xnor: WIDTH must be 18 or 32");
    end
  endgenerate

  // XNOR feedback: all-ones locks up, all-zeros is a legal state
  logic fb;
  assign fb = ~^(q & TAPS);

  // State register: reset loads seed, enable shifts toward the MSB, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed;
    end else if (enable) begin
      q <= {q[WIDTH-2:0], fb};
    end
  end

endmodule

// File: tb/tb_lfsr_xnor.sv
// tb/tb_lfsr_xnor.sv - self-checking bench for lfsr_xnor at widths 32 and 18
module tb_lfsr_xnor;

  logic        clk;
  logic        rst32, en32;
  logic [31:0] seed32, q32;
  logic        rst18, en18;
  logic [17:0] seed18, q18;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_xnor #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .seed(seed32), .enable(en32), .q(q32)
  );

  lfsr_xnor #(.WIDTH(18)) dut18 (
    .clk(clk), .reset(rst18), .seed(seed18), .enable(en18), .q(q18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [31:0] seed;
    int          n;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] getq(input int w);
    return (w == 32) ? q32 : {14'd0, q18};
  endfunction

  // Reference step from the tap list: feedback is 1 when an even number of tap bits are set
  function automatic logic [31:0] ref_next(input int w, input logic [31:0] s);
    int ones;
    logic [31:0] nxt;
    if (w == 32) begin
      ones = int'((s >> 31) & 1) + int'((s >> 21) & 1) + int'((s >> 1) & 1) + int'(s & 1);
      nxt  = (s << 1) + ((ones % 2 == 0) ? 32'd1 : 32'd0);
    end else begin
      ones = int'((s >> 17) & 1) + int'((s >> 10) & 1);
      nxt  = ((s << 1) + ((ones % 2 == 0) ? 32'd1 : 32'd0)) % 32'h40000;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] all_ones(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : 32'h0003_FFFF;
  endfunction

  task automatic set_rst(input int w, input logic v);
    if (w == 32) rst32 = v; else rst18 = v;
  endtask

  task automatic set_en(input int w, input logic v);
    if (w == 32) en32 = v; else en18 = v;
  endtask

  task automatic set_seed(input int w, input logic [31:0] s);
    if (w == 32) seed32 = s; else seed18 = s[17:0];
  endtask

  // Reset between edges, confirm the async load, release after the next edge
  task automatic do_reset(input int w, input logic [31:0] s);
    @(posedge clk); #1;
    set_en(w, 1'b0);
    set_seed(w, s);
    set_rst(w, 1'b1);
    #1;
    check("reset_load", getq(w), s);
    @(posedge clk); #1;
    set_rst(w, 1'b0);
  endtask

  task automatic run_steps(input int w, input int n);
    set_en(w, 1'b1);
    repeat (n) begin
      @(posedge clk); #1;
    end
    set_en(w, 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] held;
    logic [31:0] s;
    int          cnt;
    int          w;

    rst32 = 1'b1; en32 = 1'b0; seed32 = 32'hAAAA_CCCC;
    rst18 = 1'b1; en18 = 1'b0; seed18 = 18'h0_AACC;
    #2;
    check("por_q32", q32, 32'hAAAA_CCCC);
    check("por_q18", {14'd0, q18}, 32'h0000_AACC);
    @(posedge clk); #1;
    rst32 = 1'b0; rst18 = 1'b0;

    // Directed vectors from fixed seeds
    vecs.push_back('{32, 32'hAAAA_CCCC, 0,  32'hAAAA_CCCC, "w32_seed"});
    vecs.push_back('{32, 32'hAAAA_CCCC, 1,  32'h5555_9999, "w32_step1"});
    vecs.push_back('{32, 32'hAAAA_CCCC, 2,  32'hAAAB_3332, "w32_step2"});
    vecs.push_back('{18, 32'h0000_AACC, 0,  32'h0000_AACC, "w18_seed"});
    vecs.push_back('{18, 32'h0000_AACC, 1,  32'h0001_5599, "w18_step1"});
    vecs.push_back('{18, 32'h0000_AACC, 2,  32'h0002_AB32, "w18_step2"});
    vecs.push_back('{32, 32'h0000_0000, 1,  32'h0000_0001, "w32_zero_step"});
    vecs.push_back('{18, 32'h0000_0000, 1,  32'h0000_0001, "w18_zero_step"});
    vecs.push_back('{32, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, "w32_lockup"});
    vecs.push_back('{18, 32'h0003_FFFF, 10, 32'h0003_FFFF, "w18_lockup"});

    foreach (vecs[i]) begin
      do_reset(vecs[i].w, vecs[i].seed);
      run_steps(vecs[i].w, vecs[i].n);
      check(vecs[i].name, getq(vecs[i].w), vecs[i].exp);
    end

    // Hold: 24 steps, 4 held clocks, then resume on the unbroken sequence
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 18;
      s = $urandom() & all_ones(w);
      if (s == all_ones(w)) s = s ^ 32'd1;
      do_reset(w, s);
      m = s;
      set_en(w, 1'b1);
      for (int i = 0; i < 24; i++) begin
        @(posedge clk); #1;
        m = ref_next(w, m);
        check("hold_run", getq(w), m);
      end
      set_en(w, 1'b0);
      held = getq(w);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        check("hold_stable", getq(w), m);
      end
      set_en(w, 1'b1);
      @(posedge clk); #1;
      set_en(w, 1'b0);
      m = ref_next(w, m);
      check("hold_resume", getq(w), m);
      check("hold_moved", {31'd0, getq(w) != held}, 32'd1);
    end

    // Async reset mid-run with enable kept high
    do_reset(32, 32'hCAFE_0001);
    en32 = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    seed32 = 32'h1234_5678;
    rst32  = 1'b1;
    #1;
    check("async_before_edge", q32, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("async_held_en", q32, 32'h1234_5678);
    end
    @(negedge clk);
    rst32 = 1'b0;
    @(posedge clk); #1;
    en32 = 1'b0;
    check("async_release_step", q32, ref_next(32, 32'h1234_5678));

    // Random seeds and enable patterns against the reference model
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 18;
      for (int r = 0; r < 4; r++) begin
        s = $urandom() & all_ones(w);
        if (s == all_ones(w)) s = s ^ 32'd2;
        do_reset(w, s);
        m = s;
        for (int i = 0; i < 50; i++) begin
          logic e;
          e = 1'($urandom_range(0, 1));
          set_en(w, e);
          @(posedge clk); #1;
          if (e) m = ref_next(w, m);
          check("random_seq", getq(w), m);
        end
        set_en(w, 1'b0);
      end
    end

    // Period at width 18 from the all-zeros seed
    do_reset(18, 32'd0);
    en18 = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (q18 != 18'd0 && cnt < 270000);
    en18 = 1'b0;
    check("period_18", cnt, 32'd262143);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
